// File: rtl/ctrl_pkg.sv
// ctrl_pkg
// Shared definitions for the control sequencer: opcode values, the bit
// position of every datapath enable inside the 24-bit Ctrl word, the ALU
// operation codes the fetch/address steps drive, the sequencer state
// encoding and two small helpers that describe instruction length and
// which execute steps talk to memory.
package ctrl_pkg;

  // Opcode values as they appear in IR[IR_W-1 -: OP_W]
  localparam int unsigned OP_LD   = 0;
  localparam int unsigned OP_LDI  = 1;
  localparam int unsigned OP_ST   = 2;
  localparam int unsigned OP_ADD  = 3;
  localparam int unsigned OP_SUB  = 4;
  localparam int unsigned OP_AND  = 5;
  localparam int unsigned OP_OR   = 6;
  localparam int unsigned OP_ROR  = 7;
  localparam int unsigned OP_ROL  = 8;
  localparam int unsigned OP_SHR  = 9;
  localparam int unsigned OP_SHRA = 10;
  localparam int unsigned OP_SHL  = 11;
  localparam int unsigned OP_ADDI = 12;
  localparam int unsigned OP_ANDI = 13;
  localparam int unsigned OP_ORI  = 14;
  localparam int unsigned OP_DIV  = 15;
  localparam int unsigned OP_MUL  = 16;
  localparam int unsigned OP_NEG  = 17;
  localparam int unsigned OP_NOT  = 18;
  localparam int unsigned OP_BR   = 19;
  localparam int unsigned OP_JR   = 20;
  localparam int unsigned OP_JAL  = 21;
  localparam int unsigned OP_IN   = 22;
  localparam int unsigned OP_OUT  = 23;
  localparam int unsigned OP_MFHI = 24;
  localparam int unsigned OP_MFLO = 25;
  localparam int unsigned OP_NOP  = 26;
  localparam int unsigned OP_HALT = 27;

  // Ctrl word layout: Gra is the MSB, Cout the LSB
  localparam int CTRL_W      = 24;
  localparam int C_GRA       = 23;
  localparam int C_GRB       = 22;
  localparam int C_GRC       = 21;
  localparam int C_RIN       = 20;
  localparam int C_ROUT      = 19;
  localparam int C_BAOUT     = 18;
  localparam int C_CONIN     = 17;
  localparam int C_HIIN      = 16;
  localparam int C_LOIN      = 15;
  localparam int C_ZIN       = 14;
  localparam int C_PCIN      = 13;
  localparam int C_MDRIN     = 12;
  localparam int C_MARIN     = 11;
  localparam int C_YIN       = 10;
  localparam int C_OUTPORTIN = 9;
  localparam int C_IRIN      = 8;
  localparam int C_HIOUT     = 7;
  localparam int C_LOOUT     = 6;
  localparam int C_ZHIGHOUT  = 5;
  localparam int C_ZLOWOUT   = 4;
  localparam int C_PCOUT     = 3;
  localparam int C_MDROUT    = 2;
  localparam int C_INPORTOUT = 1;
  localparam int C_COUT      = 0;

  // ALU codes; INC is all-ones at whatever ALU width is in use, so it is
  // kept as -1 and width-cast where it is driven.
  localparam int unsigned ALU_ADD = 3;
  localparam int          ALU_INC = -1;

  // Sequencer phases; the step counter selects T0..T2 / S3..S7 within them
  localparam logic [2:0] ST_RESET  = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_PAUSE  = 3'd3;
  localparam logic [2:0] ST_HALTED = 3'd4;

  // Final execute step of each instruction
  function automatic logic [2:0] last_step(input logic [31:0] op);
    logic [2:0] s;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA,
      OP_SHL, OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: s = 3'd5;
      OP_NEG, OP_NOT, OP_JAL:                   s = 3'd4;
      OP_DIV, OP_MUL, OP_BR:                    s = 3'd6;
      OP_LD, OP_ST:                             s = 3'd7;
      default:                                  s = 3'd3;
    endcase
    return s;
  endfunction

  // Execute steps that wait on MemRdy when handshaking is enabled
  function automatic logic is_mem_step(input logic [31:0] op, input logic [2:0] step);
    return ((op == OP_LD) && (step == 3'd6)) || ((op == OP_ST) && (step == 3'd7));
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode
// Purely combinational output decode for the control sequencer.
// Ports:
//   state    in  phase of the sequencer (ST_* from ctrl_pkg)
//   step     in  step within the phase (0..2 fetch, 3..7 execute)
//   opcode   in  opcode latched at the end of T2
//   con_ff   in  branch condition, consumed in br S6
//   ctrl     out datapath enables (ctrl_pkg C_* bit layout)
//   alu_code out ALU operation select
//   read     out memory read strobe
//   write    out memory write strobe
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OP_W  = 5,
  parameter int ALU_W = 5
) (
  input  logic [2:0]        state,
  input  logic [2:0]        step,
  input  logic [OP_W-1:0]   opcode,
  input  logic              con_ff,
  output logic [CTRL_W-1:0] ctrl,
  output logic [ALU_W-1:0]  alu_code,
  output logic              read,
  output logic              write
);

  logic [31:0] op_ext;
  logic        imm;

  assign op_ext = 32'(opcode);
  assign imm    = (op_ext == OP_ADDI) || (op_ext == OP_ANDI) || (op_ext == OP_ORI);

  // Everything defaults to 0; each (phase, step, opcode) only raises the
  // enables it needs, so RESET, PAUSE and HALTED decode to all-zero.
  always_comb begin
    ctrl     = '0;
    alu_code = '0;
    read     = 1'b0;
    write    = 1'b0;
    case (state)
      ST_FETCH: begin
        case (step)
          3'd0: begin
            ctrl[C_PCOUT] = 1'b1;
            ctrl[C_MARIN] = 1'b1;
            ctrl[C_ZIN]   = 1'b1;
            alu_code      = ALU_W'(ALU_INC);
          end
          3'd1: begin
            ctrl[C_ZLOWOUT] = 1'b1;
            ctrl[C_PCIN]    = 1'b1;
            ctrl[C_MDRIN]   = 1'b1;
            read            = 1'b1;
          end
          3'd2: begin
            ctrl[C_MDROUT] = 1'b1;
            ctrl[C_IRIN]   = 1'b1;
          end
          default: ;
        endcase
      end
      ST_EXEC: begin
        case (op_ext)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA,
          OP_SHL, OP_ADDI, OP_ANDI, OP_ORI: begin
            case (step)
              3'd3: begin
                ctrl[C_GRB]  = 1'b1;
                ctrl[C_ROUT] = 1'b1;
                ctrl[C_YIN]  = 1'b1;
              end
              3'd4: begin
                // Immediate forms take the second operand from the C field
                if (imm) begin
                  ctrl[C_COUT] = 1'b1;
                end else begin
                  ctrl[C_GRC]  = 1'b1;
                  ctrl[C_ROUT] = 1'b1;
                end
                ctrl[C_ZIN] = 1'b1;
                alu_code    = ALU_W'(op_ext);
              end
              3'd5: begin
                ctrl[C_ZLOWOUT] = 1'b1;
                ctrl[C_GRA]     = 1'b1;
                ctrl[C_RIN]     = 1'b1;
              end
              default: ;
            endcase
          end
          OP_NEG, OP_NOT: begin
            case (step)
              3'd3: begin
                ctrl[C_GRB]  = 1'b1;
                ctrl[C_ROUT] = 1'b1;
                ctrl[C_ZIN]  = 1'b1;
                alu_code     = ALU_W'(op_ext);
              end
              3'd4: begin
                ctrl[C_ZLOWOUT] = 1'b1;
                ctrl[C_GRA]     = 1'b1;
                ctrl[C_RIN]     = 1'b1;
              end
              default: ;
            endcase
          end
          OP_MUL, OP_DIV: begin
            case (step)
              3'd3: begin
                ctrl[C_GRA]  = 1'b1;
                ctrl[C_ROUT] = 1'b1;
                ctrl[C_YIN]  = 1'b1;
              end
              3'd4: begin
                ctrl[C_GRB]  = 1'b1;
                ctrl[C_ROUT] = 1'b1;
                ctrl[C_ZIN]  = 1'b1;
                alu_code     = ALU_W'(op_ext);
              end
              3'd5: begin
                ctrl[C_ZLOWOUT] = 1'b1;
                ctrl[C_LOIN]    = 1'b1;
              end
              3'd6: begin
                ctrl[C_ZHIGHOUT] = 1'b1;
                ctrl[C_HIIN]     = 1'b1;
              end
              default: ;
            endcase
          end
          OP_LD, OP_LDI, OP_ST: begin
            case (step)
              3'd3: begin
                ctrl[C_GRB]   = 1'b1;
                ctrl[C_BAOUT] = 1'b1;
                ctrl[C_YIN]   = 1'b1;
              end
              3'd4: begin
                ctrl[C_COUT] = 1'b1;
                ctrl[C_ZIN]  = 1'b1;
                alu_code     = ALU_W'(ALU_ADD);
              end
              3'd5: begin
                // ldi writes the effective address itself; ld/st send it to MAR
                ctrl[C_ZLOWOUT] = 1'b1;
                if (op_ext == OP_LDI) begin
                  ctrl[C_GRA] = 1'b1;
                  ctrl[C_RIN] = 1'b1;
                end else begin
                  ctrl[C_MARIN] = 1'b1;
                end
              end
              3'd6: begin
                ctrl[C_MDRIN] = 1'b1;
                if (op_ext == OP_ST) begin
                  ctrl[C_GRA]  = 1'b1;
                  ctrl[C_ROUT] = 1'b1;
                end else begin
                  read = 1'b1;
                end
              end
              3'd7: begin
                if (op_ext == OP_ST) begin
                  write = 1'b1;
                end else begin
                  ctrl[C_MDROUT] = 1'b1;
                  ctrl[C_GRA]    = 1'b1;
                  ctrl[C_RIN]    = 1'b1;
                end
              end
              default: ;
            endcase
          end
          OP_BR: begin
            case (step)
              3'd3: begin
                ctrl[C_GRA]   = 1'b1;
                ctrl[C_ROUT]  = 1'b1;
                ctrl[C_CONIN] = 1'b1;
              end
              3'd4: begin
                ctrl[C_PCOUT] = 1'b1;
                ctrl[C_YIN]   = 1'b1;
              end
              3'd5: begin
                ctrl[C_COUT] = 1'b1;
                ctrl[C_ZIN]  = 1'b1;
                alu_code     = ALU_W'(ALU_ADD);
              end
              3'd6: begin
                // Taken branch loads PC+offset; not taken leaves PC alone
                ctrl[C_ZLOWOUT] = con_ff;
                ctrl[C_PCIN]    = con_ff;
              end
              default: ;
            endcase
          end
          OP_JAL: begin
            case (step)
              3'd3: begin
                ctrl[C_GRB]   = 1'b1;
                ctrl[C_RIN]   = 1'b1;
                ctrl[C_PCOUT] = 1'b1;
              end
              3'd4: begin
                ctrl[C_GRA]  = 1'b1;
                ctrl[C_ROUT] = 1'b1;
                ctrl[C_PCIN] = 1'b1;
              end
              default: ;
            endcase
          end
          OP_JR: begin
            if (step == 3'd3) begin
              ctrl[C_GRA]  = 1'b1;
              ctrl[C_ROUT] = 1'b1;
              ctrl[C_PCIN] = 1'b1;
            end
          end
          OP_IN: begin
            if (step == 3'd3) begin
              ctrl[C_INPORTOUT] = 1'b1;
              ctrl[C_GRA]       = 1'b1;
              ctrl[C_RIN]       = 1'b1;
            end
          end
          OP_OUT: begin
            if (step == 3'd3) begin
              ctrl[C_GRA]       = 1'b1;
              ctrl[C_ROUT]      = 1'b1;
              ctrl[C_OUTPORTIN] = 1'b1;
            end
          end
          OP_MFLO: begin
            if (step == 3'd3) begin
              ctrl[C_LOOUT] = 1'b1;
              ctrl[C_GRA]   = 1'b1;
              ctrl[C_RIN]   = 1'b1;
            end
          end
          OP_MFHI: begin
            if (step == 3'd3) begin
              ctrl[C_HIOUT] = 1'b1;
              ctrl[C_GRA]   = 1'b1;
              ctrl[C_RIN]   = 1'b1;
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer
// Multi-cycle control sequencer: fetches, decodes and steps through each
// instruction, driving the datapath enables from registered state.
// Ports:
//   Clock   in  sole clock, rising edge
//   Reset   in  synchronous active-high reset
//   IR      in  instruction word; opcode is the top OP_W bits
//   Stop    in  pause request, honoured only at an instruction boundary
//   CON_FF  in  branch condition flag
//   MemRdy  in  memory completion strobe (used when MEM_HS != 0)
//   Ctrl    out datapath enables, Gra in bit 23 down to Cout in bit 0
//   ALUCode out ALU operation select
//   Read    out memory read strobe
//   Write   out memory write strobe
//   Run     out high while fetching or executing
//   Illegal out sticky undefined-opcode flag
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int OP_W   = 5,
  parameter int IR_W   = 32,
  parameter int ALU_W  = 5,
  parameter int MEM_HS = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [IR_W-1:0]   IR,
  input  logic              Stop,
  input  logic              CON_FF,
  input  logic              MemRdy,
  output logic [CTRL_W-1:0] Ctrl,
  output logic [ALU_W-1:0]  ALUCode,
  output logic              Read,
  output logic              Write,
  output logic              Run,
  output logic              Illegal
);

  logic [2:0]      state;
  logic [2:0]      step;
  logic [OP_W-1:0] opcode;
  logic [31:0]     ir_op;
  logic [31:0]     cur_op;
  logic            mem_step;
  logic            hold;
  logic            ir_unused;

  assign ir_op     = 32'(IR[IR_W-1 -: OP_W]);
  assign cur_op    = 32'(opcode);
  assign ir_unused = ^IR[IR_W-OP_W-1:0];

  // A memory step stalls until MemRdy; Stop cannot break the stall since
  // it is only looked at when the last step completes.
  assign mem_step = ((state == ST_FETCH) && (step == 3'd1)) ||
                    ((state == ST_EXEC) && is_mem_step(cur_op, step));
  assign hold     = (MEM_HS != 0) && mem_step && !MemRdy;

  assign Run = (state == ST_FETCH) || (state == ST_EXEC);

  // Phase/step sequencing. The opcode is captured on the T2 edge so the
  // execute steps do not depend on IR staying put afterwards.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= ST_RESET;
      step    <= 3'd0;
      opcode  <= '0;
      Illegal <= 1'b0;
    end else begin
      case (state)
        ST_RESET: begin
          state <= ST_FETCH;
          step  <= 3'd0;
        end
        ST_FETCH: begin
          if (!hold) begin
            if (step == 3'd2) begin
              opcode <= IR[IR_W-1 -: OP_W];
              if (ir_op == OP_NOP) begin
                state <= Stop ? ST_PAUSE : ST_FETCH;
                step  <= 3'd0;
              end else if (ir_op == OP_HALT) begin
                state <= ST_HALTED;
              end else if (ir_op > OP_HALT) begin
                state   <= ST_HALTED;
                Illegal <= 1'b1;
              end else begin
                state <= ST_EXEC;
                step  <= 3'd3;
              end
            end else begin
              step <= step + 3'd1;
            end
          end
        end
        ST_EXEC: begin
          if (!hold) begin
            if (step == last_step(cur_op)) begin
              state <= Stop ? ST_PAUSE : ST_FETCH;
              step  <= 3'd0;
            end else begin
              step <= step + 3'd1;
            end
          end
        end
        ST_PAUSE: begin
          if (!Stop) begin
            state <= ST_FETCH;
            step  <= 3'd0;
          end
        end
        ST_HALTED: ;
        default: begin
          state <= ST_RESET;
          step  <= 3'd0;
        end
      endcase
    end
  end

  ctrl_decode #(
    .OP_W  (OP_W),
    .ALU_W (ALU_W)
  ) u_decode (
    .state    (state),
    .step     (step),
    .opcode   (opcode),
    .con_ff   (CON_FF),
    .ctrl     (Ctrl),
    .alu_code (ALUCode),
    .read     (Read),
    .write    (Write)
  );

endmodule
